// File: rtl/chip8_key_ctrl.sv
// CHIP-8 keypad: per-key debounce, registered key query and FX0A wait FSM; outputs 1 cycle after inputs, no backpressure.
// Define CHIP8_KEY_RELEASE_EN to complete FX0A on release of the captured key instead of on its press.
module chip8_key_ctrl #(
  parameter int DEBOUNCE_SAMPLES = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] key_pressed_in,
  input  logic        key_valid_in,
  output logic [15:0] keys_stable_out,
  input  logic [3:0]  query_key_in,
  output logic        query_pressed_out,
  input  logic        wait_req_in,
  input  logic        cancel_in,
  output logic        wait_busy_out,
  output logic        wait_done_out,
  output logic [3:0]  wait_key_out
);

  localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(DEBOUNCE_SAMPLES - 1);

`ifdef CHIP8_KEY_RELEASE_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ARMED = 2'd1, ST_HELD = 2'd2, ST_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ARMED = 2'd1, ST_DONE = 2'd3} state_t;
`endif

  logic [CW-1:0] r_cnt [16];
  logic [CW-1:0] w_cnt_nxt [16];
  logic [15:0]   r_stable;
  logic [15:0]   w_stable_nxt;
  logic [15:0]   r_prev;
  logic          r_query;
  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic [3:0]    r_key;
  logic [15:0]   w_rise;
  logic          w_rise_any;
  logic [3:0]    w_rise_idx;

  always_comb begin
    w_stable_nxt = r_stable;
    for (int i = 0; i < 16; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (key_valid_in) begin
        if (key_pressed_in[i] == r_stable[i]) begin
          w_cnt_nxt[i] = '0;
        end else if (r_cnt[i] == LP_LAST) begin
          w_stable_nxt[i] = ~r_stable[i];
          w_cnt_nxt[i]    = '0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_rise     = r_stable & ~r_prev;
  assign w_rise_any = |w_rise;

  // Descending scan so the lowest rising index wins.
  always_comb begin
    w_rise_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_rise[i]) w_rise_idx = 4'(i);
    end
  end

`ifdef CHIP8_KEY_RELEASE_EN
  logic [15:0] w_fall;
  assign w_fall = ~r_stable & r_prev;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 16; i++) r_cnt[i] <= '0;
      r_stable <= '0;
      r_prev   <= '0;
      r_query  <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_stable <= w_stable_nxt;
      r_prev   <= r_stable;
      r_query  <= r_stable[query_key_in];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_key   <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (wait_req_in && !cancel_in) begin
            r_state <= ST_ARMED;
            r_busy  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (cancel_in) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_rise_any) begin
            r_key <= w_rise_idx;
`ifdef CHIP8_KEY_RELEASE_EN
            r_state <= ST_HELD;
`else
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`endif
          end
        end
`ifdef CHIP8_KEY_RELEASE_EN
        ST_HELD: begin
          if (cancel_in) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_fall[r_key]) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
`endif
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign keys_stable_out   = r_stable;
  assign query_pressed_out = r_query;
  assign wait_busy_out     = r_busy;
  assign wait_done_out     = r_done;
  assign wait_key_out      = r_key;

endmodule

// File: doc/chip8_key_ctrl.md
CHIP8_KEY_CTRL -- requirements
Module: chip8_key_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_SAMPLES, default 3, consecutive disagreeing scan samples before a key's stable state changes (legal range 1..15).
REQ-002 SHALL have port clk_in input 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_in input 1, synchronous active-low reset.
REQ-004 SHALL have port key_pressed_in input 16, raw scanner key vector (bit i = key i held).
REQ-005 SHALL have port key_valid_in input 1, one-cycle strobe marking a fresh key_pressed_in sample.
REQ-006 SHALL have port keys_stable_out output 16, debounced key state.
REQ-007 SHALL have port query_key_in input 4, key index for EX9E/EXA1 queries.
REQ-008 SHALL have port query_pressed_out output 1, debounced state of the queried key.
REQ-009 SHALL have port wait_req_in input 1, pulse that starts an FX0A wait.
REQ-010 SHALL have port cancel_in input 1, pulse that aborts a wait.
REQ-011 SHALL have port wait_busy_out output 1, high while a wait is in progress.
REQ-012 SHALL have port wait_done_out output 1, one-cycle completion pulse.
REQ-013 SHALL have port wait_key_out output 4, captured key index, valid while wait_done_out is high and held until the next capture.

Function
REQ-014 SHALL keep one count per key, with width ceil(log2(DEBOUNCE_SAMPLES+1)) bits.
REQ-015 Debounce behaviour per key when key_valid_in=1:
- raw equals stable: count cleared.
- raw differs from stable: count incremented; on reaching DEBOUNCE_SAMPLES, stable bit toggles and count clears.
REQ-016 When key_valid_in=0, counts and keys_stable_out SHALL hold.
REQ-017 A stable change SHALL be visible on keys_stable_out the cycle after the qualifying strobe; DEBOUNCE_SAMPLES=1 gives immediate follow.
REQ-018 query_pressed_out SHALL be a registered copy of keys_stable_out[query_key_in], with 1-cycle latency.
REQ-019 SHALL keep stable_prev, a registered copy of keys_stable_out.
- rise[i] = stable & ~prev.
- fall[i] = ~stable & prev.
REQ-020 FSM states SHALL be IDLE, ARMED, HELD, DONE.
REQ-021 IDLE -> ARMED on wait_req_in=1 (with cancel_in=0); wait_busy_out high from the next cycle.
REQ-022 In ARMED, on any rise in cycle T: capture the lowest-index rising key into wait_key_out; go to HELD at T+1.
REQ-023 Keys already stable-pressed at arm time SHALL NOT satisfy the wait; a fresh rise is required.
REQ-024 In HELD, a fall of the captured key in cycle R -> DONE at R+1. Rises and falls of other keys are ignored.
REQ-025 DONE SHALL last exactly one cycle: wait_done_out=1, wait_busy_out=0; then IDLE.
REQ-026 wait_req_in while not IDLE SHALL be ignored.
REQ-027 cancel_in SHALL force IDLE from ARMED or HELD next cycle with no wait_done_out; cancel_in beats wait_req_in in the same cycle.
REQ-028 cancel_in in DONE SHALL NOT suppress the already-asserted pulse.

Reset
REQ-029 rst_in=0 at a clock edge SHALL clear:
- keys_stable_out, stable_prev, all counts;
- query_pressed_out, wait_busy_out, wait_done_out, wait_key_out;
- FSM to IDLE.
REQ-030 Reset mid-wait SHALL abort with no done pulse; reset SHALL override all inputs.

Configuration
REQ-031 Macro CHIP8_KEY_RELEASE_EN defined: the wait completes on release, per REQ-022..REQ-025.
REQ-032 Macro CHIP8_KEY_RELEASE_EN undefined: HELD is not implemented; ARMED -> DONE directly.
- A rise in cycle T gives wait_done_out at T+1 with the captured key.

Verification (DEBOUNCE_SAMPLES=3)
REQ-033 Bench SHALL cover debounce: key 5 raw high for 3 strobes -> keys_stable_out=16'h0020 the cycle after the 3rd strobe; high for 2 strobes then low -> stays 16'h0000.
REQ-034 Bench SHALL cover query: stable 16'h8000, query_key_in=15 -> query_pressed_out=1 next cycle; query_key_in=0 -> 0.
REQ-035 Bench SHALL cover wait with release (macro defined):
- Pre-hold key 2, wait_req_in pulse, then keys 9 and 4 stabilise on the same strobe.
- Expect wait_key_out=4, no done while key 9 toggles.
- Release key 4 -> one-cycle wait_done_out=1 with wait_key_out=4, busy=0.
REQ-036 Bench SHALL cover wait with macro undefined: arm, key 10 rises at T -> wait_done_out=1, wait_key_out=10 at T+1, and no release is needed.
REQ-037 Bench SHALL cover cancel:
- Cancel in HELD -> IDLE, busy=0, no done.
- wait_req_in and cancel_in in the same IDLE cycle -> stays IDLE.
REQ-038 Bench SHALL cover reset: rst_in=0 for 1 cycle while in HELD with stable 16'hFFFF -> all outputs 0, FSM IDLE; a key held afterward needs 3 fresh strobes to reappear.
